spi_arduino_tx: RTL and testbench

- Reply side of the Arduino SPI link: an SPI mode‑1 responder that serialises a sequence‑tagged status frame onto the FPGA data‑out line.
- Runs entirely in the SCLK domain. Its pulse/status outputs must be synchronised by the consumer before use in the 50 MHz domain.
- Sits beside the sample receiver on the same SCLK/CS_n pins and shares the chip‑select transaction with it.

---
 rtl/spi_arduino_pkg.sv | 14 +
 rtl/spi_tx_frame_builder.sv | 33 +++
 rtl/spi_arduino_tx.sv | 135 +++++++++++++
 tb/tb_spi_arduino_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_arduino_pkg.sv
// Shared types and constants for the Arduino SPI link blocks.
package spi_arduino_pkg;

    localparam int SPI_FRAME_WIDTH = 16;
    localparam int SPI_SEQ_WIDTH   = 4;
    localparam int SPI_CNT_WIDTH   = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_DONE
    } spi_tx_state_t;

endpackage

// File: rtl/spi_tx_frame_builder.sv
// Combinational frame assembly: {sequence tag, payload}, optionally followed by an even-parity bit.
module spi_tx_frame_builder
    import spi_arduino_pkg::*;
#(
    parameter int FRAME_WIDTH = SPI_FRAME_WIDTH,
    parameter int SEQ_WIDTH   = SPI_SEQ_WIDTH,
    parameter int PARITY_EN   = 0
) (
    input  logic [SEQ_WIDTH-1:0]             seq,
    input  logic [FRAME_WIDTH-SEQ_WIDTH-1:0] payload,
    output logic [FRAME_WIDTH+PARITY_EN-1:0] frame_bits
);

    logic [FRAME_WIDTH-1:0] frame;

    always_comb begin
        frame = {seq, payload};
    end

    generate
        if (PARITY_EN != 0) begin : g_parity
            // XOR of all bits makes the total count of ones (frame + parity) even.
            always_comb begin
                frame_bits = {frame, ^frame};
            end
        end else begin : g_no_parity
            always_comb begin
                frame_bits = frame;
            end
        end
    endgenerate

endmodule

// File: rtl/spi_arduino_tx.sv
// spi_arduino_tx: SPI mode-1 responder shifting a sequence-tagged status frame out on SDI, MSB first.
// Define SPI_ARDUINO_TX_PARITY_EN to append an even-parity bit after the frame LSB.
module spi_arduino_tx
    import spi_arduino_pkg::*;
#(
    parameter int FRAME_WIDTH = SPI_FRAME_WIDTH,
    parameter int SEQ_WIDTH   = SPI_SEQ_WIDTH
) (
    input  logic                             input_SPI_SCLK,
    input  logic                             reset_n,
    input  logic                             input_SPI_CS_n,
    input  logic [FRAME_WIDTH-SEQ_WIDTH-1:0] input_statusWord,
    output logic                             output_SPI_SDI,
    output logic                             output_SPI_SDI_oe,
    output logic                             output_txBusy,
    output logic                             output_txDone,
    output logic                             output_txAbort,
    output logic [SEQ_WIDTH-1:0]             output_sequence
);

`ifdef SPI_ARDUINO_TX_PARITY_EN
    localparam int PARITY_EN = 1;
`else
    localparam int PARITY_EN = 0;
`endif
    localparam int TOTAL_BITS = FRAME_WIDTH + PARITY_EN;
    localparam logic [SPI_CNT_WIDTH-1:0] TOTAL_CNT = SPI_CNT_WIDTH'(TOTAL_BITS);

    spi_tx_state_t                state_q, state_d;
    logic [TOTAL_BITS-2:0]        shift_reg_q, shift_reg_d;
    logic [SPI_CNT_WIDTH-1:0]     bit_count_q, bit_count_d;
    logic [SEQ_WIDTH-1:0]         seq_q, seq_d;
    logic                         chipselect_q, chipselect_d;
    logic                         cs_hold_q, cs_hold_d;
    logic                         sdi_q, sdi_d;
    logic                         tx_done_q, tx_done_d;
    logic                         tx_abort_q, tx_abort_d;

    logic [TOTAL_BITS-1:0]        frame_bits;
    logic                         start;

    spi_tx_frame_builder #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .SEQ_WIDTH   (SEQ_WIDTH),
        .PARITY_EN   (PARITY_EN)
    ) u_frame_builder (
        .seq        (seq_q),
        .payload    (input_statusWord),
        .frame_bits (frame_bits)
    );

    // A reset landing inside a held-low transaction must not restart mid-transaction,
    // so cs_hold blocks starts until CS_n has been seen high once.
    always_comb begin
        start = chipselect_q & ~input_SPI_CS_n & ~cs_hold_q;
    end

    always_comb begin
        state_d      = state_q;
        shift_reg_d  = shift_reg_q;
        bit_count_d  = bit_count_q;
        seq_d        = seq_q;
        chipselect_d = input_SPI_CS_n;
        cs_hold_d    = cs_hold_q & ~input_SPI_CS_n;
        sdi_d        = 1'b0;
        tx_done_d    = 1'b0;
        tx_abort_d   = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    sdi_d       = frame_bits[TOTAL_BITS-1];
                    shift_reg_d = frame_bits[TOTAL_BITS-2:0];
                    bit_count_d = SPI_CNT_WIDTH'(1);
                    state_d     = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (bit_count_q == TOTAL_CNT) begin
                    // Every bit has already been sampled, so completion beats a late CS_n rise.
                    tx_done_d = 1'b1;
                    seq_d     = seq_q + SEQ_WIDTH'(1);
                    state_d   = input_SPI_CS_n ? TX_IDLE : TX_DONE;
                end else if (input_SPI_CS_n) begin
                    tx_abort_d = 1'b1;
                    state_d    = TX_IDLE;
                end else begin
                    sdi_d       = shift_reg_q[TOTAL_BITS-2];
                    shift_reg_d = {shift_reg_q[TOTAL_BITS-3:0], 1'b0};
                    bit_count_d = bit_count_q + SPI_CNT_WIDTH'(1);
                end
            end
            TX_DONE: begin
                if (input_SPI_CS_n) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge input_SPI_SCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= TX_IDLE;
            shift_reg_q  <= '0;
            bit_count_q  <= '0;
            seq_q        <= '0;
            chipselect_q <= 1'b1;
            cs_hold_q    <= 1'b1;
            sdi_q        <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_abort_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_reg_q  <= shift_reg_d;
            bit_count_q  <= bit_count_d;
            seq_q        <= seq_d;
            chipselect_q <= chipselect_d;
            cs_hold_q    <= cs_hold_d;
            sdi_q        <= sdi_d;
            tx_done_q    <= tx_done_d;
            tx_abort_q   <= tx_abort_d;
        end
    end

    assign output_SPI_SDI    = sdi_q;
    assign output_SPI_SDI_oe = (state_q == TX_SHIFT);
    assign output_txBusy     = (state_q == TX_SHIFT);
    assign output_txDone     = tx_done_q;
    assign output_txAbort    = tx_abort_q;
    assign output_sequence   = seq_q;

endmodule

// File: tb/tb_spi_arduino_tx.sv
// Self-checking bench for spi_arduino_tx: edge-level behavioural model plus directed literal checks.
module tb_spi_arduino_tx;

`ifdef SPI_ARDUINO_TX_PARITY_EN
    localparam int TOTAL = 17;
`else
    localparam int TOTAL = 16;
`endif

    logic        sclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1;
    logic [11:0] status = '0;
    wire         sdi, oe, busy, done, abort;
    wire  [3:0]  seq;

    spi_arduino_tx dut (
        .input_SPI_SCLK   (sclk),
        .reset_n          (reset_n),
        .input_SPI_CS_n   (cs_n),
        .input_statusWord (status),
        .output_SPI_SDI   (sdi),
        .output_SPI_SDI_oe(oe),
        .output_txBusy    (busy),
        .output_txDone    (done),
        .output_txAbort   (abort),
        .output_sequence  (seq)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a list of TOTAL bits; k is the index of the bit currently on SDI.
    typedef struct {
        bit              in_frame;
        int              k;
        bit              prev_cs;
        bit              armed;
        logic [TOTAL-1:0] bits;
        int              seq;
        bit              done;
        bit              abort;
        bit              sdi;
    } mdl_t;

    function automatic logic [TOTAL-1:0] bits_of(input int tag, input logic [11:0] st);
        logic [15:0] f;
        f = {4'(tag), st};
`ifdef SPI_ARDUINO_TX_PARITY_EN
        return {f, ^f};
`else
        return f;
`endif
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.in_frame = 0; s.k = 0; s.prev_cs = 1; s.armed = 0; s.bits = '0;
        s.seq = 0; s.done = 0; s.abort = 0; s.sdi = 0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input logic c, input logic [11:0] st);
        mdl_t n;
        n = s;
        n.done = 0; n.abort = 0; n.sdi = 0;
        if (s.in_frame) begin
            if (s.k + 1 == TOTAL) begin
                n.done = 1; n.seq = (s.seq + 1) % 16; n.in_frame = 0;
            end else if (c) begin
                n.abort = 1; n.in_frame = 0;
            end else begin
                n.k = s.k + 1; n.sdi = s.bits[TOTAL-1-n.k];
            end
        end else if (s.armed && s.prev_cs && !c) begin
            n.in_frame = 1; n.k = 0; n.bits = bits_of(s.seq, st); n.sdi = n.bits[TOTAL-1];
        end
        if (c) n.armed = 1;
        n.prev_cs = c;
        return n;
    endfunction

    mdl_t m = mdl_reset();

    always @(posedge sclk or negedge reset_n) begin
        if (!reset_n) m <= mdl_reset();
        else          m <= mdl_step(m, cs_n, status);
    end

    always @(negedge sclk) begin
        chk("sdi",   sdi,   m.sdi);
        chk("oe",    oe,    m.in_frame);
        chk("busy",  busy,  m.in_frame);
        chk("done",  done,  m.done);
        chk("abort", abort, m.abort);
        chk("seq",   seq,   32'(m.seq % 16));
    end

    logic [31:0] rx = '0;
    int n_done = 0, n_abort = 0, n_oe = 0;
    always @(negedge sclk) begin
        if (oe) begin
            rx   <= {rx[30:0], sdi};
            n_oe <= n_oe + 1;
        end
        if (done)  n_done  <= n_done + 1;
        if (abort) n_abort <= n_abort + 1;
    end

    function automatic logic [31:0] sel(input logic [31:0] plain, input logic [31:0] par);
`ifdef SPI_ARDUINO_TX_PARITY_EN
        return par;
`else
        return plain;
`endif
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic run_frame(input logic [11:0] st, input logic [11:0] mid, input int change_at);
        status = st;
        cs_n   = 1'b0;
        for (int i = 0; i < TOTAL + 1; i++) begin
            @(negedge sclk);
            if (i == change_at) status = mid;
        end
        cs_n = 1'b1;
        cyc(2);
    endtask

    function automatic logic [31:0] rx_frame();
        logic [31:0] r;
        r = rx;
        return r & ((32'h1 << TOTAL) - 1);
    endfunction

    initial begin
        int d0, a0, o0;
        reset_n = 1'b0; cs_n = 1'b1; status = '0;
        cyc(2);
        chk("rst_sdi", sdi, 0); chk("rst_oe", oe, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_abort", abort, 0); chk("rst_seq", seq, 0);
        reset_n = 1'b1;
        cyc(2);

        // normal frame
        d0 = n_done;
        run_frame(12'hABC, 12'hABC, 99);
        chk("f1_stream", rx_frame(), sel(32'h0ABC, 32'h1579));
        chk("f1_done_cnt", 32'(n_done - d0), 1);
        chk("f1_seq", seq, 1);
`ifdef SPI_ARDUINO_TX_PARITY_EN
        chk("f1_parity_bit", rx[0], 1);
`endif

        // payload change mid-frame must not leak into the frame
        run_frame(12'h123, 12'hFFF, 6);
        chk("f2_stream", rx_frame(), sel(32'h1123, 32'h2247));
        chk("f2_seq", seq, 2);

        // abort after 5 bits
        a0 = n_abort; d0 = n_done;
        status = 12'h555; cs_n = 1'b0;
        cyc(5);
        cs_n = 1'b1;
        cyc(2);
        chk("ab_cnt", 32'(n_abort - a0), 1);
        chk("ab_no_done", 32'(n_done - d0), 0);
        chk("ab_oe", oe, 0);
        chk("ab_seq", seq, 2);
        run_frame(12'h555, 12'h555, 99);
        chk("f3_stream", rx_frame(), sel(32'h2555, 32'h4AAB));
        chk("f3_seq", seq, 3);

        // 13 more completions bring the total to 16, wrapping the tag to 0
        for (int i = 3; i < 16; i++) run_frame(12'(i * 17), 12'(i * 17), 99);
        chk("wrap_seq", seq, 0);
        run_frame(12'h0F0, 12'h0F0, 99);
        chk("f17_stream", rx_frame(), sel(32'h00F0, 32'h01E0));
        chk("f17_seq", seq, 1);

        // reset in the middle of a frame, CS kept low afterwards
        status = 12'hABC; cs_n = 1'b0;
        cyc(7);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_sdi", sdi, 0); chk("mrst_oe", oe, 0);
        chk("mrst_busy", busy, 0); chk("mrst_seq", seq, 0);
        cyc(2);
        reset_n = 1'b1;
        o0 = n_oe;
        cyc(4);
        chk("mrst_no_start", 32'(n_oe - o0), 0);
        cs_n = 1'b1;
        cyc(1);
        run_frame(12'hABC, 12'hABC, 99);
        chk("mrst_stream", rx_frame(), sel(32'h0ABC, 32'h1579));
        chk("mrst_seq", seq, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
